// File: rtl/udp_tx_sched.sv
// Two-client round-robin scheduler that hands a shared UDP TX buffer to the engine and muxes reads.
// Define UDP_TX_SCHED_TIMEOUT_EN to build the transfer timeout (err0/err1); otherwise err is tied 0.
module udp_tx_sched #(
  parameter int unsigned AWIDTH      = 6,
  parameter int unsigned TIMEOUT_CYC = 250000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              sel,
  input  logic              txbuf_cpu_grant,
  output logic              txbuf_cpu_rel,
  input  logic [AWIDTH-1:0] txbuf_addr,
  input  logic              txbuf_ce,
  output logic [31:0]       txbuf_rdata,
  output logic [AWIDTH-1:0] cli0_addr,
  output logic [AWIDTH-1:0] cli1_addr,
  output logic              cli0_ce,
  output logic              cli1_ce,
  input  logic [31:0]       cli0_rdata,
  input  logic [31:0]       cli1_rdata
);

  typedef enum logic [1:0] {StIdle, StRel, StXmit, StDone} state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       rel_q, rel_d;
  logic       seen_low_q, seen_low_d;
  logic       last_q, last_d;
  logic [1:0] ack_q, ack_d;
  logic       winner;

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // On a tie the client not served last wins.
  assign winner = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    rel_d      = 1'b0;
    seen_low_d = seen_low_q;
    last_d     = last_q;
    ack_d      = 2'b00;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 2'b00;
`endif
    unique case (state_q)
      StIdle: begin
        if (txbuf_cpu_grant && (req0 || req1)) begin
          state_d = StRel;
          sel_d   = winner;
          busy_d  = 1'b1;
          rel_d   = 1'b1;
        end
      end
      StRel: begin
        state_d = StXmit;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StXmit: begin
        if (!txbuf_cpu_grant) seen_low_d = 1'b1;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // Completion needs a full grant round trip: low first, then high again.
        if (txbuf_cpu_grant && seen_low_q) begin
          state_d = StDone;
          ack_d   = sel_q ? 2'b10 : 2'b01;
        end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        else if (cnt_d == CntW'(TIMEOUT_CYC - 1)) begin
          state_d = StDone;
          ack_d   = sel_q ? 2'b10 : 2'b01;
          err_d   = sel_q ? 2'b10 : 2'b01;
        end
`endif
      end
      StDone: begin
        state_d    = StIdle;
        busy_d     = 1'b0;
        last_d     = sel_q;
        seen_low_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      busy_q     <= 1'b0;
      rel_q      <= 1'b0;
      seen_low_q <= 1'b0;
      last_q     <= 1'b1;
      ack_q      <= 2'b00;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 2'b00;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      rel_q      <= rel_d;
      seen_low_q <= seen_low_d;
      last_q     <= last_d;
      ack_q      <= ack_d;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign ack0          = ack_q[0];
  assign ack1          = ack_q[1];
`ifdef UDP_TX_SCHED_TIMEOUT_EN
  assign err0          = err_q[0];
  assign err1          = err_q[1];
`else
  assign err0          = 1'b0;
  assign err1          = 1'b0;
`endif
  assign busy          = busy_q;
  assign sel           = sel_q;
  assign txbuf_cpu_rel = rel_q;

  assign cli0_addr   = txbuf_addr;
  assign cli1_addr   = txbuf_addr;
  assign cli0_ce     = txbuf_ce & busy_q & ~sel_q;
  assign cli1_ce     = txbuf_ce & busy_q & sel_q;
  assign txbuf_rdata = !busy_q ? 32'h0 : (sel_q ? cli1_rdata : cli0_rdata);

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched; a scoreboard queue holds expected {err, client} per transfer.
module tb_udp_tx_sched;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          ack0, ack1, err0, err1, busy, sel;
  logic          txbuf_cpu_grant = 1'b0;
  logic          txbuf_cpu_rel;
  logic [AW-1:0] txbuf_addr = '0;
  logic          txbuf_ce = 1'b0;
  logic [31:0]   txbuf_rdata;
  logic [AW-1:0] cli0_addr, cli1_addr;
  logic          cli0_ce, cli1_ce;
  logic [31:0]   cli0_rdata = 32'h0, cli1_rdata = 32'h0;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int sb_q[$];

  udp_tx_sched #(.AWIDTH(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .busy(busy), .sel(sel),
    .txbuf_cpu_grant(txbuf_cpu_grant), .txbuf_cpu_rel(txbuf_cpu_rel),
    .txbuf_addr(txbuf_addr), .txbuf_ce(txbuf_ce), .txbuf_rdata(txbuf_rdata),
    .cli0_addr(cli0_addr), .cli1_addr(cli1_addr), .cli0_ce(cli0_ce), .cli1_ce(cli1_ce),
    .cli0_rdata(cli0_rdata), .cli1_rdata(cli1_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every ack must match the oldest expected {err, client}.
  always @(negedge clk) begin
    int got;
    int exp;
    if (rst_n && (ack0 || ack1 || err0 || err1)) begin
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
      got = (ack1 ? 1 : 0) + ((err0 || err1) ? 2 : 0);
      check("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
      check("ack_scoreboard", got, exp);
      ack_cnt++;
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_ack"}, {ack1, ack0}, 0);
    check({tag, "_err"}, {err1, err0}, 0);
    check({tag, "_rel"}, txbuf_cpu_rel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_ce"}, {cli1_ce, cli0_ce}, 0);
    check({tag, "_rdata"}, txbuf_rdata, 0);
  endtask

  task automatic wait_rel(input string tag);
    int n = 0;
    while (!txbuf_cpu_rel && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, txbuf_cpu_rel, 1);
  endtask

  task automatic wait_ack(input int a0, input int lim, input string tag, output int n);
    n = 0;
    while (ack_cnt == a0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, ack_cnt != a0, 1);
  endtask

  // One full transfer; called at a negedge. raise1 drops req0 after selection and raises req1.
  task automatic run_xfer(input bit r0, input bit r1, input int exp_cli, input int low_cyc,
                          input bit raise1);
    int a0;
    int n;
    logic [AW-1:0] addr;
    req0 = r0;
    req1 = r1;
    sb_q.push_back(exp_cli);
    a0 = ack_cnt;
    wait_rel("rel_seen");
    check("sel_at_rel", sel, exp_cli[0]);
    check("busy_at_rel", busy, 1);
    if (raise1) begin
      req0 = 1'b0;
      req1 = 1'b1;
    end
    txbuf_cpu_grant = 1'b0;
    @(negedge clk);
    check("rel_one_cycle", txbuf_cpu_rel, 0);
    txbuf_ce = 1'b1;
    txbuf_addr = '0;
    cli0_rdata = 32'h11223344;
    cli1_rdata = 32'h0a01a8c0;
    #1;
    check("rdata_mux", txbuf_rdata, exp_cli[0] ? 32'h0a01a8c0 : 32'h11223344);
    check("ce_route", {cli1_ce, cli0_ce}, exp_cli[0] ? 2'b10 : 2'b01);
    txbuf_ce = 1'b0;
    addr = AW'($urandom_range(1, 63));
    txbuf_addr = addr;
    #1;
    check("ce_gated", {cli1_ce, cli0_ce}, 0);
    check("addr_pass", {cli1_addr, cli0_addr}, {addr, addr});
    repeat (low_cyc - 1) @(negedge clk);
    txbuf_cpu_grant = 1'b1;
    wait_ack(a0, 20, "ack_seen", n);
    req0 = 1'b0;
    if (!raise1) req1 = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {ack1, ack0}, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int n;
    // Reset: outputs quiet even with read enable and client data active.
    txbuf_ce = 1'b1;
    cli0_rdata = 32'hdeadbeef;
    cli1_rdata = 32'hcafef00d;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst_n = 1'b1;
    txbuf_cpu_grant = 1'b1;
    txbuf_ce = 1'b0;
    @(negedge clk);
    check("idle_no_req", busy, 0);

    // Ties from reset alternate 0,1,0.
    run_xfer(1, 1, 0, 3, 0);
    run_xfer(1, 1, 1, 3, 0);
    run_xfer(1, 1, 0, 3, 0);
    // Single requester with 10-cycle grant drop.
    run_xfer(1, 0, 0, 10, 0);
    // Client 1 datapath in XMIT.
    run_xfer(0, 1, 1, 4, 0);
    // req0 dropped after selection still acked; req1 raised while busy served next.
    run_xfer(1, 0, 0, 5, 1);
    run_xfer(0, 1, 1, 4, 0);

    // Grant low in IDLE blocks arbitration; a withdrawn request is forgotten.
    a0 = ack_cnt;
    txbuf_cpu_grant = 1'b0;
    req0 = 1'b1;
    repeat (3) @(negedge clk);
    check("grant_low_blocks", busy, 0);
    req0 = 1'b0;
    @(negedge clk);
    txbuf_cpu_grant = 1'b1;
    repeat (10) @(negedge clk);
    check("withdrawn_req_busy", busy, 0);
    check("withdrawn_req_ack", ack_cnt - a0, 0);

`ifndef UDP_TX_SCHED_TIMEOUT_EN
    // Grant never dropping must not complete the transfer.
    a0 = ack_cnt;
    req0 = 1'b1;
    sb_q.push_back(0);
    wait_rel("stuck_rel");
    repeat (100) @(negedge clk);
    check("stuck_no_ack", ack_cnt - a0, 0);
    check("stuck_busy", busy, 1);
    txbuf_cpu_grant = 1'b0;
    repeat (2) @(negedge clk);
    txbuf_cpu_grant = 1'b1;
    wait_ack(a0, 20, "stuck_release_ack", n);
    req0 = 1'b0;
    @(negedge clk);
`else
    // Grant never returns: ack0 with err0 exactly 16 cycles after REL.
    a0 = ack_cnt;
    req0 = 1'b1;
    sb_q.push_back(2);
    wait_rel("timeout_rel");
    txbuf_cpu_grant = 1'b0;
    wait_ack(a0, 40, "timeout_ack", n);
    check("timeout_latency", n, 16);
    txbuf_cpu_grant = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("timeout_idle", busy, 0);
`endif

    // Reset mid-XMIT abandons the transfer and restores the tie pointer.
    req1 = 1'b1;
    wait_rel("abort_rel");
    txbuf_cpu_grant = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_sel", sel, 1);
    rst_n = 1'b0;
    req1 = 1'b0;
    txbuf_ce = 1'b1;
    sb_q.delete();
    #1;
    check_quiet("abort_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txbuf_ce = 1'b0;
    txbuf_cpu_grant = 1'b1;
    a0 = ack_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_ack", ack_cnt - a0, 0);
    run_xfer(1, 1, 0, 3, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
